// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction field
// positions and default datapath sizes.
package alu_issue_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_N_DEF  = 8;
    localparam int REG_AW     = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LI  = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 7;
    localparam int RT_MSB  = 6;
    localparam int RT_LSB  = 4;
    localparam int SH_MSB  = 3;
    localparam int SH_LSB  = 0;
    localparam int IMM_MSB = 9;
    localparam int IMM_W   = 10;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the issue stage: two decode read ports, one debug read
// port, one synchronous write port. r0 always reads zero and ignores writes.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_N];

    function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] addr);
        return (addr == '0) ? '0 : mem[addr];
    endfunction

    assign rdata_a  = rd_port(raddr_a);
    assign rdata_b  = rd_port(raddr_b);
    assign dbg_data = rd_port(dbg_addr);

    // Clear all registers on reset; otherwise commit writes except to r0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand stage feeding a combinational 16-bit ALU. Instructions are
// accepted over valid/ready, operands are read from the register file and
// registered into the EX slot, and the ALU result is written back at the end
// of the EX cycle.
// Optional macro ALU_ISSUE_FWD_EN: enables EX->decode forwarding. Without it a
// read-after-write hazard on the EX destination inserts one bubble instead.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              stall,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        ALUop,
    output logic [3:0]        shamt,
    output logic              ex_valid,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic              zero_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [2:0]        op;
    logic [REG_AW-1:0] rd, rs, rt;
    logic              is_li, is_shift, accept;
    logic [DATA_W-1:0] rs_data, rt_data, rs_val, rt_val;
    logic [DATA_W-1:0] a_d, b_d;
    logic [2:0]        op_d;
    logic [3:0]        sh_d;

    logic [DATA_W-1:0] a_p1, b_p1;
    logic [2:0]        op_p1;
    logic [3:0]        sh_p1;
    logic [REG_AW-1:0] rd_p1;
    logic              vld_p1, zf_p1, wr_en;

    assign op       = instr[OP_MSB:OP_LSB];
    assign rd       = instr[RD_MSB:RD_LSB];
    assign rs       = instr[RS_MSB:RS_LSB];
    assign rt       = instr[RT_MSB:RT_LSB];
    assign is_li    = (op == OP_LI);
    assign is_shift = is_shift_op(op);
    assign accept   = in_valid & in_ready;

    // A write happens whenever a live, unstalled EX slot targets a real register.
    assign wr_en = rst_n & vld_p1 & ~stall & (rd_p1 != '0);

    alu_issue_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd_p1),
        .wdata    (alu_result),
        .raddr_a  (rs),
        .raddr_b  (rt),
        .dbg_addr (dbg_addr),
        .rdata_a  (rs_data),
        .rdata_b  (rt_data),
        .dbg_data (dbg_data)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_rs, fwd_rt;
    // The EX result is written this edge, so the register file still holds the old value.
    assign fwd_rs   = vld_p1 & (rd_p1 != '0) & (rd_p1 == rs);
    assign fwd_rt   = vld_p1 & (rd_p1 != '0) & (rd_p1 == rt);
    assign rs_val   = fwd_rs ? alu_result : rs_data;
    assign rt_val   = fwd_rt ? alu_result : rt_data;
    assign in_ready = ~stall & rst_n;
`else
    logic uses_rt, hazard;
    // Hold decode one cycle so the EX result lands in the register file first.
    assign uses_rt  = ~is_li & ~is_shift;
    assign hazard   = vld_p1 & (rd_p1 != '0) &
                      ((~is_li & (rd_p1 == rs)) | (uses_rt & (rd_p1 == rt)));
    assign rs_val   = rs_data;
    assign rt_val   = rt_data;
    assign in_ready = ~stall & ~hazard & rst_n;
`endif

    // Form the EX operands from the decoded instruction.
    always_comb begin
        a_d  = rs_val;
        b_d  = rt_val;
        op_d = op;
        sh_d = '0;
        if (is_li) begin
            a_d  = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_MSB:0]};
            b_d  = '0;
            op_d = OP_ADD;
        end else if (is_shift) begin
            b_d  = '0;
            sh_d = instr[SH_MSB:SH_LSB];
        end
    end

    // EX slot: load on accept, hold under stall, otherwise go empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= OP_ADD;
            sh_p1  <= '0;
            rd_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                a_p1   <= a_d;
                b_p1   <= b_d;
                op_p1  <= op_d;
                sh_p1  <= sh_d;
                rd_p1  <= rd;
                vld_p1 <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Capture the ALU zero flag for every completing instruction, r0 targets included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zf_p1 <= 1'b0;
        end else if (vld_p1 && !stall) begin
            zf_p1 <= alu_zero;
        end
    end

    assign A         = a_p1;
    assign B         = b_p1;
    assign ALUop     = op_p1;
    assign shamt     = sh_p1;
    assign ex_valid  = vld_p1;
    assign wb_en     = wr_en;
    assign wb_addr   = rd_p1;
    assign zero_flag = zf_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU closes the loop,
// a vector table drives the main instruction stream and a scoreboard checks
// every writeback; stall, r0 and reset-in-flight are hand sequences.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
    localparam int BUBBLE = 0;
`else
    localparam int BUBBLE = 1;
`endif

    logic        clk, rst_n, in_valid, in_ready, stall;
    logic [15:0] instr, alu_result, A, B, dbg_data;
    logic        alu_zero, ex_valid, wb_en, zero_flag;
    logic [2:0]  ALUop, wb_addr, dbg_addr;
    logic [3:0]  shamt;

    typedef struct {
        logic [15:0] w;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] ev;
        bit          dep;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
    } wb_t;

    vec_t tbl[11];
    wb_t  sbq[$];
    int   checks, errors, wb_count;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .stall      (stall),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .A          (A),
        .B          (B),
        .ALUop      (ALUop),
        .shamt      (shamt),
        .ex_valid   (ex_valid),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .zero_flag  (zero_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [15:0] alu_model(input logic [15:0] a, b, input logic [2:0] op,
                                              input logic [3:0] sh);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b011:  return a << sh;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'b111:  return a >> sh;
            default: return 16'd0;
        endcase
    endfunction

    assign alu_result = alu_model(A, B, ALUop, shamt);
    assign alu_zero   = (alu_result == 16'd0);

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd, rs, rt,
                                        input logic [3:0] sh);
        return {op, rd, rs, rt, sh};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd, input logic [9:0] imm);
        return {OP_LI, rd, imm};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("reg_r%0d", a), dbg_data, exp);
    endtask

    // Offer one instruction, wait (bounded) for acceptance, check the EX slot.
    task automatic issue(input logic [15:0] w, input logic [15:0] ea, eb, ev, output int waits);
        logic [2:0] rd;
        logic [2:0] eop;
        logic [3:0] esh;
        rd  = w[12:10];
        eop = (w[15:13] == OP_LI) ? OP_ADD : w[15:13];
        esh = (w[15:13] == OP_SLL || w[15:13] == OP_SRL) ? w[3:0] : 4'd0;
        in_valid = 1'b1;
        instr    = w;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout instr 0x%0h never accepted, want in_ready=1", w);
            in_valid = 1'b0;
            return;
        end
        if (rd != 3'd0) begin
            wb_t e;
            e.rd  = rd;
            e.val = ev;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("opA", A, ea);
        chk("opB", B, eb);
        chk("aluop", ALUop, eop);
        chk("shamt", shamt, esh);
        chk("ex_valid_issue", ex_valid, 1);
    endtask

    // Scoreboard: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_en) begin
            wb_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected addr %0d data 0x%0h, want no writeback", wb_addr, alu_result);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("wb_addr", wb_addr, e.rd);
                chk("wb_data", alu_result, e.val);
            end
        end
    end

    initial begin
        int waits;
        int wb0;
        checks   = 0;
        errors   = 0;
        wb_count = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b1;
        instr    = enc(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0);
        dbg_addr = 3'd0;

        // Reset with a valid instruction pending.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_zero_flag", zero_flag, 0);
        for (int a = 0; a < 8; a++) check_reg(3'(a), 16'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        tbl[0]  = '{li(3'd1, 10'd16),                         16'd16,    16'd0,     16'd16,    1'b0};
        tbl[1]  = '{li(3'd2, 10'd34),                         16'd34,    16'd0,     16'd34,    1'b0};
        tbl[2]  = '{enc(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0),      16'd16,    16'd34,    16'd50,    1'b1};
        tbl[3]  = '{enc(OP_SUB, 3'd4, 3'd3, 3'd1, 4'd0),      16'd50,    16'd16,    16'd34,    1'b1};
        tbl[4]  = '{enc(OP_SLT, 3'd5, 3'd1, 3'd2, 4'd0),      16'd16,    16'd34,    16'd1,     1'b0};
        tbl[5]  = '{enc(OP_SLT, 3'd5, 3'd2, 3'd1, 4'd0),      16'd34,    16'd16,    16'd0,     1'b0};
        tbl[6]  = '{li(3'd6, 10'h2DE),                        16'h02DE,  16'd0,     16'h02DE,  1'b0};
        tbl[7]  = '{enc(OP_SLL, 3'd7, 3'd6, 3'd0, 4'd1),      16'h02DE,  16'd0,     16'h05BC,  1'b1};
        tbl[8]  = '{enc(OP_SRL, 3'd7, 3'd6, 3'd0, 4'd2),      16'h02DE,  16'd0,     16'h00B7,  1'b0};
        tbl[9]  = '{enc(OP_AND, 3'd1, 3'd6, 3'd6, 4'd0),      16'h02DE,  16'h02DE,  16'h02DE,  1'b0};
        tbl[10] = '{enc(OP_SUB, 3'd0, 3'd1, 3'd1, 4'd0),      16'h02DE,  16'h02DE,  16'd0,     1'b1};

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].w, tbl[i].ea, tbl[i].eb, tbl[i].ev, waits);
            chk($sformatf("bubbles_vec%0d", i), waits, tbl[i].dep ? BUBBLE : 0);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        check_reg(3'd0, 16'd0);
        check_reg(3'd1, 16'h02DE);
        check_reg(3'd2, 16'd34);
        check_reg(3'd3, 16'd50);
        check_reg(3'd4, 16'd34);
        check_reg(3'd5, 16'd0);
        check_reg(3'd6, 16'h02DE);
        check_reg(3'd7, 16'h00B7);
        chk("zf_r0_sub", zero_flag, 1);

        // A non-zero result aimed at r0: flag clears, r0 stays zero, no write.
        wb0 = wb_count;
        issue(enc(OP_ADD, 3'd0, 3'd1, 3'd2, 4'd0), 16'h02DE, 16'd34, 16'h0300, waits);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("zf_r0_add", zero_flag, 0);
        check_reg(3'd0, 16'd0);
        chk("r0_no_wb", wb_count - wb0, 0);

        // Stall three cycles with an ADD in EX.
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0), 16'h02DE, 16'd34, 16'h0300, waits);
        in_valid = 1'b0;
        stall    = 1'b1;
        wb0      = wb_count;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wb_en", wb_en, 0);
            chk("stall_A", A, 16'h02DE);
            chk("stall_B", B, 16'd34);
            chk("stall_aluop", ALUop, OP_ADD);
            chk("stall_ex_valid", ex_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        check_reg(3'd3, 16'd50);
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_release_writes", wb_count - wb0, 1);
        check_reg(3'd3, 16'h0300);
        chk("stall_release_ex_valid", ex_valid, 0);
        @(posedge clk);
        #1;
        chk("stall_single_write", wb_count - wb0, 1);

        // Reset arriving while an instruction is in EX drops it.
        wb0 = wb_count;
        issue(enc(OP_ADD, 3'd3, 3'd2, 3'd2, 4'd0), 16'd34, 16'd34, 16'd68, waits);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_ex_valid", ex_valid, 0);
        check_reg(3'd3, 16'd0);
        check_reg(3'd1, 16'd0);
        chk("midrst_no_wb", wb_count - wb0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand stage directly upstream of alu16. Accepts 16-bit instructions over a valid/ready handshake, reads an 8x16 register file and drives A, B, ALUop and shamt to the combinational ALU from a registered EX slot.
- Writes the ALU Result back to the register file at the end of the EX cycle.
- Provides one-deep forwarding from EX to decode, so back-to-back dependent instructions issue without bubbles.

Parameters:
- DATA_W, 16, datapath width; must match alu16.
- REG_N, 8, register count; register address width is 3 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction present on instr.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  16  instruction word.
- stall  in  1  downstream hold; freezes the EX slot and suppresses writeback.
- alu_result  in  16  Result from alu16.
- alu_zero  in  1  Zero from alu16.
- A  out  16  ALU operand A (registered).
- B  out  16  ALU operand B (registered).
- ALUop  out  3  ALU operation code (registered).
- shamt  out  4  shift amount (registered).
- ex_valid  out  1  EX slot holds a live instruction.
- wb_en  out  1  writeback occurs at this clock edge (= ex_valid & ~stall & ex_rd!=0).
- wb_addr  out  3  destination register of the EX slot.
- zero_flag  out  1  alu_zero captured at the last writeback.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational register file read of dbg_addr.

Behaviour:
- Instruction encoding:
  - op=instr[15:13], rd=[12:10], rs=[9:7], rt=[6:4], shamt=[3:0].
  - op codes: 000 ADD, 001 SUB, 011 SLL, 100 AND, 101 OR, 110 SLT, 111 SRL. These are passed unchanged to ALUop.
  - op 010 = LI: rd <= zero-extended instr[9:0]. Issued as ALUop=000, A=imm, B=0, shamt=0.
- Operand selection:
  - Shifts (011, 111): A=R[rs], B=0, shamt=instr[3:0].
  - Other ALU ops: A=R[rs], B=R[rt], shamt=0.
- r0 is hardwired to zero: reads return 0 and writes are discarded.
- Accept condition: in_valid & in_ready at a rising edge.
  - in_ready = ~stall (also gated by the hazard rule under the optional feature).
  - On accept, the EX slot loads A/B/ALUop/shamt/ex_rd and ex_valid<=1. Otherwise ex_valid<=0 unless stall holds it.
- Latency: instruction accepted at edge N → operands valid at N → R[rd] written at edge N+1 (if no stall) → visible on dbg_data after N+1.
- Stall:
  - EX slot, ex_valid and all outputs hold their values.
  - No writeback; in_ready=0.
  - When stall drops, the held instruction writes back at the next edge.
- Forwarding:
  - Condition: decoding while ex_valid & ex_rd!=0 & ex_rd==rs (or rt).
  - The operand takes alu_result instead of the register file value.
  - Applies to both A and B independently.
- Simultaneous writeback and accept at the same edge: the register file updates and the new EX slot loads. Forwarding guarantees the new operands are correct.
- zero_flag updates only on edges where ex_valid & ~stall, including writes targeting r0.
- Reset (rst_n=0 at an edge):
  - All registers r0..r7 <= 0.
  - A, B <= 0; ALUop <= 000; shamt <= 0.
  - ex_valid <= 0; zero_flag <= 0.
  - An in-flight instruction is dropped with no writeback.
  - in_ready = 0 while rst_n=0.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: forwarding as above; in_ready = ~stall & rst_n.
- Undefined: no forwarding path. A RAW hazard (ex_valid & ex_rd!=0 & ex_rd matches a used source) forces in_ready=0 for that cycle. Exactly one bubble is inserted, then the instruction issues with register-file operands.
- Architectural results are identical in both builds.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_LI=3'b010, OP_SLL=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_SLT=3'b110, OP_SRL=3'b111;
  - field bit positions;
  - DATA_W/REG_N defaults.
- One sub-module, alu_issue_regfile: 8x16 storage, two combinational read ports plus the debug port, one synchronous write port, r0 forced to zero.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → ex_valid=0, wb_en=0, in_ready=0, dbg_data=0 for all 8 addresses.
- Back-to-back dependency: LI r1,16; LI r2,34; ADD r3,r1,r2 on consecutive cycles → A=16, B=34 for the ADD; R[3]=50 one edge after the ADD issues.
  - FWD_EN build: no bubble.
  - Non-FWD build: in_ready low exactly 1 cycle before the ADD issues.
- Arithmetic: from the state above, SUB r4,r3,r1 → R[4]=34. Then SLT r5,r1,r2 → R[5]=1. Then SLT r5,r2,r1 → R[5]=0.
- Shifts and logic: LI r6,0x2DE; SLL r7,r6,shamt=1 → R[7]=0x05BC, B=0. Then SRL r7,r6,shamt=2 → R[7]=0x00B7. Then AND r1,r6,r6 → R[1]=0x02DE.
- Stall: assert stall for 3 cycles with an ADD in EX → A/B/ALUop held, wb_en=0, register unchanged. Deassert → single write of the correct value.
- r0 and reset mid-flight:
  - ADD r0,r1,r2 → dbg r0 stays 0 and zero_flag still updates.
  - Issue ADD r3 then pulse rst_n=0 on the next edge → R[3]=0, ex_valid=0.
